// File: rtl/regfile_read_arbiter_if.sv
// Handshake bundle between the read clients, the shared register-file read
// port and the arbiter. The arbiter takes the slave side.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [ADDR_WIDTH-1:0]         rd_sel;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic [NUM_REQ-1:0]            resp_ready;
  logic                          busy;

  modport slave (
    input  req_valid, req_addr, rd_data, resp_ready,
    output req_ready, rd_sel, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req_addr, rd_data, resp_ready,
    input  req_ready, rd_sel, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the single register-file read port: one read in
// flight, registered mux select, registered response data.

module regfile_read_arbiter_lane #(
  parameter int PTR_W = 2,
  parameter int IDX   = 0
) (
  input  logic [PTR_W-1:0] ptr,
  input  logic             req_valid,
  input  logic             in_resp,
  input  logic [PTR_W-1:0] owner,
  output logic             upper_req,
  output logic             resp_valid
);
  localparam logic [PTR_W-1:0] IDX_L = PTR_W'(IDX);

  // Lanes at or above the pointer win before lanes that wrapped around.
  assign upper_req  = req_valid && (IDX_L >= ptr);
  assign resp_valid = in_resp && (owner == IDX_L);
endmodule

module regfile_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_read_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] rd_sel_q, rd_sel_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0]    upper_req;
  logic [NUM_REQ-1:0]    lane_resp;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  upper_hit, any_hit, gnt_vld, accept, owner_ready;
  logic [PTR_W-1:0]      upper_idx, any_idx, gnt_idx;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    regfile_read_arbiter_lane #(
      .PTR_W (PTR_W),
      .IDX   (i)
    ) u_lane (
      .ptr        (ptr_q),
      .req_valid  (bus.req_valid[i]),
      .in_resp    (state_q == RESP),
      .owner      (owner_q),
      .upper_req  (upper_req[i]),
      .resp_valid (lane_resp[i])
    );
  end

  // Lowest set index wins in each half; the upper half has priority.
  always_comb begin
    upper_hit = 1'b0;
    any_hit   = 1'b0;
    upper_idx = '0;
    any_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        upper_hit = 1'b1;
        upper_idx = PTR_W'(i);
      end
      if (bus.req_valid[i]) begin
        any_hit = 1'b1;
        any_idx = PTR_W'(i);
      end
    end
    gnt_idx = upper_hit ? upper_idx : any_idx;
    gnt_vld = any_hit && (state_q == IDLE) && !reset;
  end

  always_comb begin
    req_ready_c = '0;
    gnt_addr    = '0;
    owner_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_c[i] = gnt_vld && (gnt_idx == PTR_W'(i));
      if (gnt_idx == PTR_W'(i))
        gnt_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (owner_q == PTR_W'(i))
        owner_ready = bus.resp_ready[i];
    end
  end

  assign accept = |(req_ready_c & bus.req_valid);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    rd_sel_d    = rd_sel_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_sel_d = gnt_addr;
          owner_d  = gnt_idx;
          ptr_d    = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
          state_d  = ISSUE;
        end
      end
      // rd_sel has been stable for a full cycle, so the mux output is settled.
      ISSUE: begin
        resp_data_d = bus.rd_data;
        state_d     = RESP;
      end
      RESP: begin
        if (owner_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      rd_sel_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rd_sel_q    <= rd_sel_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = reset ? '0 : lane_resp;
  assign bus.rd_sel     = rd_sel_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench: the driver keeps a transaction-level arbiter model and
// queues expected responses; a monitor checks whatever the DUT presents.
module tb_regfile_read_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_read_arbiter_if bus ();

  regfile_read_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] mem_val(input logic [4:0] a);
    return {16'hA5A5, 11'h0, a};
  endfunction

  assign bus.rd_data = mem_val(bus.rd_sel);

  typedef struct {
    int          owner;
    logic [31:0] data;
  } txn_t;

  txn_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          done   = 0;
  bit          m_known = 0;
  int          phase  = 0;   // 0 idle, 1 waiting for capture, 2 responding
  int          mptr   = 0;
  int          mown   = 0;
  logic [4:0]  m_sel  = '0;
  logic [31:0] m_data = '0;
  logic [3:0]  exp_rr = '0;
  logic [3:0]  exp_rv = '0;
  bit          chk_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // One clock cycle: drive, predict, then advance the model after the monitor has looked.
  task automatic cycle(input logic [3:0] v, input logic [19:0] a, input logic [3:0] rr, input logic rst);
    int nph;
    logic [4:0]  nsel;
    logic [31:0] ndata;
    @(negedge clock);
    reset          = rst;
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.resp_ready = rr;
    #1;
    exp_rr = '0;
    exp_rv = '0;
    chk_busy = !rst;
    nph = phase; nsel = m_sel; ndata = m_data;
    if (rst) begin
      nph = 0; mptr = 0; mown = 0; nsel = '0; ndata = '0;
      if (phase != 0) sb.delete();
    end else if (phase == 0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (mptr + k) % 4;
        if (v[j]) begin
          exp_rr[j] = 1'b1;
          nsel = a[j*5 +: 5];
          sb.push_back('{owner: j, data: mem_val(a[j*5 +: 5])});
          mown = j;
          mptr = (j + 1) % 4;
          nph  = 1;
          break;
        end
      end
    end else if (phase == 1) begin
      nph = 2;
      if (sb.size() > 0) ndata = sb[0].data;
    end else begin
      exp_rv[mown] = 1'b1;
      if (rr[mown]) nph = 0;
    end
    #3;
    phase  = nph;
    m_sel  = nsel;
    m_data = ndata;
    if (rst) m_known = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000, pk(0, 0, 0, 0), 4'b1111, 1'b0);
  endtask

  always @(negedge clock) begin
    #3;
    if (!done && m_known) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      chk("rd_sel", 32'(bus.rd_sel), 32'(m_sel));
      chk("resp_data_reg", bus.resp_data, m_data);
      if (chk_busy) chk("busy", 32'(bus.busy), 32'(phase != 0));
      if (|bus.resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 32'(bus.resp_valid), 32'(0));
        end else begin
          chk("resp_owner", 32'(bus.resp_valid), 32'(1) << sb[0].owner);
          chk("resp_payload", bus.resp_data, sb[0].data);
          if (|(bus.resp_valid & bus.resp_ready)) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] pend;
    cycle(4'b0000, pk(0, 0, 0, 0), 4'b0000, 1'b1);
    cycle(4'b0000, pk(0, 0, 0, 0), 4'b0000, 1'b1);
    idle(1);
    // single request, address 7
    cycle(4'b0001, pk(7, 0, 0, 0), 4'b1111, 1'b0);
    idle(3);
    // pointer skip: ptr=1, requesters 0 and 3 valid
    for (int i = 0; i < 6; i++) cycle(4'b1001, pk(9, 0, 0, 12), 4'b1111, 1'b0);
    idle(3);
    // all four valid, immediate resp_ready
    for (int i = 0; i < 15; i++) cycle(4'b1111, pk(1, 2, 3, 4), 4'b1111, 1'b0);
    idle(3);
    // back-pressure on requester 2
    cycle(4'b0100, pk(0, 0, 17, 0), 4'b1011, 1'b0);
    for (int i = 0; i < 6; i++) cycle(4'b0000, pk(0, 0, 3, 0), 4'b1011, 1'b0);
    idle(3);
    // non-owner resp_ready ignored
    cycle(4'b0010, pk(0, 22, 0, 0), 4'b1101, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b0000, pk(0, 0, 0, 0), 4'b1101, 1'b0);
    idle(3);
    // reset while responding, then address 31
    cycle(4'b0001, pk(5, 0, 0, 0), 4'b0000, 1'b0);
    cycle(4'b0000, pk(0, 0, 0, 0), 4'b0000, 1'b0);
    cycle(4'b0000, pk(0, 0, 0, 0), 4'b0000, 1'b0);
    cycle(4'b0000, pk(0, 0, 0, 0), 4'b0000, 1'b1);
    cycle(4'b0100, pk(0, 0, 31, 0), 4'b1111, 1'b0);
    idle(4);
    // randomized traffic
    pend = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) pend[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
      cycle(pend, 20'($urandom), 4'($urandom), 1'($urandom_range(0, 199) == 0));
      for (int i = 0; i < 4; i++)
        if (exp_rr[i] && ($urandom_range(0, 1) == 1)) pend[i] = 1'b0;
    end
    idle(10);
    chk("drain_empty", 32'(sb.size()), 32'(0));
    done = 1;
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
